// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC sequencing, IR capture and fetch timeout
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic [19:0] Instr,
    output logic [11:0] Src2,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        FAULT      = 2'd3
    } state_t;

    // The counter saturates at 255, so larger limits fault once saturation is reached.
    localparam logic [8:0] WAIT_LIMIT = (MAX_WAIT > 255) ? 9'd256 : 9'(MAX_WAIT);

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [7:0]  wait_cnt;
    logic [8:0]  wait_inc;
    logic        timeout;
    logic        unused_bits;

    assign wait_inc    = {1'b0, wait_cnt} + 9'd1;
    assign timeout     = (wait_inc >= WAIT_LIMIT);
    assign unused_bits = ^Result[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            RESET_WAIT: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = HOLD;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (advance) begin
                    state_next = FETCH;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_VECTOR;
            pc       <= RESET_VECTOR;
            ir       <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            if (state == FETCH && imem_ack) begin
                ir       <= imem_rdata;
                pc       <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end else if (state == HOLD && advance && PCSrc) begin
                fetch_pc <= {Result[31:2], 2'b00};
            end
            // A fresh fetch always starts its timeout window from zero.
            if (state_next == FETCH && state != FETCH) begin
                wait_cnt <= 8'd0;
            end else if (state == FETCH && !imem_ack && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign imem_addr   = {fetch_pc[31:2], 2'b00};
    assign Instr       = ir[31:12];
    assign Src2        = ir[11:0];
    assign PC          = pc;
    assign PCPlus8     = pc + 32'd8;
    assign fetch_fault = (state == FAULT);

endmodule
